// File: rtl/iter_div_if.sv
// Divide-port bundle between the EX stage (master) and the iterative divider (slave).
interface iter_div_if #(
    parameter int WIDTH = 32
);
    logic                 div_start;
    logic                 div_signed;
    logic [WIDTH-1:0]     div_data1;
    logic [WIDTH-1:0]     div_data2;
    logic                 div_done;
    logic [2*WIDTH-1:0]   div_result;
    logic                 busy;

    modport master (
        output div_start, div_signed, div_data1, div_data2,
        input  div_done, div_result, busy
    );

    modport slave (
        input  div_start, div_signed, div_data1, div_data2,
        output div_done, div_result, busy
    );
endinterface

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring integer divider, WIDTH-generic.
// Result is {remainder, quotient}. Signed division truncates toward zero,
// remainder takes the dividend's sign. Divide-by-zero and (optionally)
// |dividend| < |divisor| finish in a single cycle.
module iter_div_unit #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    iter_div_if.slave  div_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // divisor magnitude
    logic                 qneg_q, qneg_d;    // quotient must be negated at the end
    logic                 rneg_q, rneg_d;    // remainder must be negated at the end
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       shifted, trial;
    logic                 fits;
    logic [WIDTH-1:0]     rem_step, quo_step, rem_fix, quo_fix;

    // Operand signs and magnitudes; MIN keeps its bit pattern, which is its correct unsigned magnitude.
    always_comb begin
        a_neg = div_if.div_signed & div_if.div_data1[WIDTH-1];
        b_neg = div_if.div_signed & div_if.div_data2[WIDTH-1];
        a_mag = a_neg ? -div_if.div_data1 : div_if.div_data1;
        b_mag = b_neg ? -div_if.div_data2 : div_if.div_data2;
    end

    // One restoring step plus the sign fix-up applied to the final step's outcome.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        // The partial remainder stays below the divisor, so bit WIDTH is a reliable borrow flag.
        fits     = ~trial[WIDTH];
        rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
        quo_fix  = qneg_q ? -quo_step : quo_step;
        rem_fix  = rneg_q ? -rem_step : rem_step;
    end

    // Next-state and datapath updates; flush overrides everything except an already-written result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (div_if.div_start) begin
                    cnt_d  = CW'(WIDTH);
                    rem_d  = '0;
                    quo_d  = a_mag;
                    dvs_d  = b_mag;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (div_if.div_data2 == '0) begin
                        result_d = {div_if.div_data1, {WIDTH{1'b1}}};
                        state_d  = S_DONE;
                    end else if (EARLY_EXIT && (a_mag < b_mag)) begin
                        result_d = {div_if.div_data1, {WIDTH{1'b0}}};
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign div_if.div_done   = (state_q == S_DONE);
    assign div_if.busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign div_if.div_result = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: three instances (32-bit with early exit, 32-bit without,
// 8-bit with early exit) checked every cycle against an arithmetic reference model,
// plus directed vectors with hand-computed results and latencies.
module tb_iter_div_unit;
    logic        clk;
    logic        rst;
    logic [2:0]  st, sg, fl;
    logic [63:0] d1 [3];
    logic [63:0] d2 [3];
    logic [2:0]  dn, bz;
    logic [63:0] rs [3];

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance
    bit          m_active [3];
    int          m_left   [3];
    logic [63:0] m_res    [3];
    logic [63:0] m_hold   [3];

    iter_div_if #(.WIDTH(32)) ifa ();
    iter_div_if #(.WIDTH(32)) ifb ();
    iter_div_if #(.WIDTH(8))  ifc ();

    iter_div_unit #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_a (.clk(clk), .rst(rst), .flush(fl[0]), .div_if(ifa));
    iter_div_unit #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_b (.clk(clk), .rst(rst), .flush(fl[1]), .div_if(ifb));
    iter_div_unit #(.WIDTH(8),  .EARLY_EXIT(1'b1)) dut_c (.clk(clk), .rst(rst), .flush(fl[2]), .div_if(ifc));

    assign ifa.div_start  = st[0];
    assign ifa.div_signed = sg[0];
    assign ifa.div_data1  = d1[0][31:0];
    assign ifa.div_data2  = d2[0][31:0];
    assign ifb.div_start  = st[1];
    assign ifb.div_signed = sg[1];
    assign ifb.div_data1  = d1[1][31:0];
    assign ifb.div_data2  = d2[1][31:0];
    assign ifc.div_start  = st[2];
    assign ifc.div_signed = sg[2];
    assign ifc.div_data1  = d1[2][7:0];
    assign ifc.div_data2  = d2[2][7:0];

    assign dn[0] = ifa.div_done;
    assign dn[1] = ifb.div_done;
    assign dn[2] = ifc.div_done;
    assign bz[0] = ifa.busy;
    assign bz[1] = ifb.busy;
    assign bz[2] = ifc.busy;
    assign rs[0] = ifa.div_result;
    assign rs[1] = ifb.div_result;
    assign rs[2] = {48'd0, ifc.div_result};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sext(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: plain integer division (SV / and % truncate toward zero), then pack.
    function automatic void ref_div(input int w, input bit ee, input bit sgn,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int lat);
        longint mask, sa, sb, q, r;
        mask = (longint'(1) << w) - 1;
        if (sgn) begin
            sa = sext(a, w);
            sb = sext(b, w);
        end else begin
            sa = longint'(a) & mask;
            sb = longint'(b) & mask;
        end
        if (sb == 0) begin
            q   = mask;
            r   = longint'(a) & mask;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            lat = (ee && (absl(sa) < absl(sb))) ? 1 : w + 1;
        end
        res = (64'(r & mask) << w) | 64'(q & mask);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of one instance, then advance its model across the coming edge.
    task automatic model_step(input int id, input int w, input bit ee,
                              input logic b_act, input logic d_act, input logic [63:0] r_act);
        logic        exp_done;
        logic [63:0] exp_res;
        logic [63:0] nres;
        int          nlat;
        exp_done = m_active[id] && (m_left[id] == 0);
        exp_res  = exp_done ? m_res[id] : m_hold[id];
        n_cmp += 3;
        if (b_act !== m_active[id]) begin
            n_bad++;
            $display("FAIL mon%0d_busy t=%0t: got %b, expected %b", id, $time, b_act, m_active[id]);
        end
        if (d_act !== exp_done) begin
            n_bad++;
            $display("FAIL mon%0d_done t=%0t: got %b, expected %b", id, $time, d_act, exp_done);
        end
        if (r_act !== exp_res) begin
            n_bad++;
            $display("FAIL mon%0d_result t=%0t: got %h, expected %h", id, $time, r_act, exp_res);
        end
        if (exp_done) m_hold[id] = m_res[id];
        if (rst) begin
            m_active[id] = 1'b0;
            m_hold[id]   = '0;
        end else if (fl[id]) begin
            m_active[id] = 1'b0;
        end else if (m_active[id]) begin
            if (exp_done) m_active[id] = 1'b0;
            else          m_left[id]   = m_left[id] - 1;
        end else if (st[id]) begin
            ref_div(w, ee, sg[id], d1[id], d2[id], nres, nlat);
            m_res[id]    = nres;
            m_left[id]   = nlat - 1;
            m_active[id] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 32, 1'b1, bz[0], dn[0], rs[0]);
        model_step(1, 32, 1'b0, bz[1], dn[1], rs[1]);
        model_step(2, 8,  1'b1, bz[2], dn[2], rs[2]);
    end

    // Issue one request, hold start until done (optionally toggling start and operands mid-run).
    task automatic issue(input int id, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                         input bit tog, output logic [63:0] res, output int lat);
        int w;
        w = (id == 2) ? 8 : 32;
        @(posedge clk); #1;
        sg[id] = sgn;
        d1[id] = a;
        d2[id] = b;
        st[id] = 1'b1;
        lat = 0;
        res = '0;
        for (int n = 1; n <= w + 8; n++) begin
            @(posedge clk); #1;
            if (dn[id]) begin
                lat    = n;
                res    = rs[id];
                st[id] = 1'b0;
                break;
            end
            if (tog) begin
                st[id] = 1'($urandom_range(0, 1));
                d1[id] = {$urandom, $urandom};
                d2[id] = {$urandom, $urandom};
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dut%0d: no div_done within %0d cycles", id, w + 8);
            st[id] = 1'b0;
        end
    endtask

    task automatic dir(input string name, input int id, input bit sgn,
                       input logic [63:0] a, input logic [63:0] b, input bit tog,
                       input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int          lat;
        issue(id, sgn, a, b, tog, res, lat);
        $display("dut%0d %s: %h / %h -> result %h after %0d cycles", id, name, a, b, res, lat);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = r & 64'hF;
            2: r = 64'd1 << (w - 1);
            3: r = '1;
            4: r = r & 64'hFFF;
            default: ;
        endcase
        return r & mask;
    endfunction

    task automatic rnd_run(input int id, input int count);
        logic [63:0] res;
        int          lat;
        int          w;
        w = (id == 2) ? 8 : 32;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < count; k++) begin
                issue(id, s[0], rnd_op(w), rnd_op(w), 1'b1, res, lat);
            end
            $display("dut%0d random %s: %0d operations issued", id, s[0] ? "signed" : "unsigned", count);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int seen;
        rst = 1'b1;
        st  = '0;
        sg  = '0;
        fl  = '0;
        for (int i = 0; i < 3; i++) begin
            d1[i]       = '0;
            d2[i]       = '0;
            m_active[i] = 1'b0;
            m_left[i]   = 0;
            m_res[i]    = '0;
            m_hold[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        chk("reset_done", 64'(dn), 64'd0);
        chk("reset_busy", 64'(bz), 64'd0);
        chk("reset_result_a", rs[0], 64'd0);
        chk("reset_result_c", rs[2], 64'd0);

        // directed vectors with hand-computed results
        dir("u100_7",     0, 1'b0, 64'd100,         64'd7,          1'b0, 64'h00000002_0000000E, 33);
        dir("u100_7_tog", 0, 1'b0, 64'd100,         64'd7,          1'b1, 64'h00000002_0000000E, 33);
        dir("s-7_2",      0, 1'b1, 64'hFFFFFFF9,    64'd2,          1'b0, 64'hFFFFFFFF_FFFFFFFD, 33);
        dir("s7_-2",      0, 1'b1, 64'd7,           64'hFFFFFFFE,   1'b0, 64'h00000001_FFFFFFFD, 33);
        dir("smin_-1",    0, 1'b1, 64'h80000000,    64'hFFFFFFFF,   1'b0, 64'h00000000_80000000, 33);
        dir("u5_0",       0, 1'b0, 64'd5,           64'd0,          1'b0, 64'h00000005_FFFFFFFF, 1);
        dir("s5_0",       0, 1'b1, 64'd5,           64'd0,          1'b0, 64'h00000005_FFFFFFFF, 1);
        dir("ee_u3_10",   0, 1'b0, 64'd3,           64'd10,         1'b0, 64'h00000003_00000000, 1);
        dir("ee_s-3_10",  0, 1'b1, 64'hFFFFFFFD,    64'd10,         1'b0, 64'hFFFFFFFD_00000000, 1);
        dir("umax_1",     0, 1'b0, 64'hFFFFFFFF,    64'd1,          1'b0, 64'h00000000_FFFFFFFF, 33);
        dir("noee_u3_10", 1, 1'b0, 64'd3,           64'd10,         1'b0, 64'h00000003_00000000, 33);
        dir("w8_-128_-1", 2, 1'b1, 64'h80,          64'hFF,         1'b0, 64'h00000000_00000080, 9);

        // flush 10 cycles into 1000/3: no done, idle next cycle, then a fresh 9/4
        @(posedge clk); #1;
        sg[0] = 1'b0; d1[0] = 64'd1000; d2[0] = 64'd3; st[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 fl[0] = 1'b1; st[0] = 1'b0;
        @(posedge clk); #1 fl[0] = 1'b0;
        $display("dut0 flush mid-run: busy %b done %b", bz[0], dn[0]);
        chk("flush_busy", 64'(bz[0]), 64'd0);
        chk("flush_done", 64'(dn[0]), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dn[0]) seen++;
        end
        chk("flush_no_late_done", 64'(seen), 64'd0);
        dir("after_flush_9_4", 0, 1'b0, 64'd9, 64'd4, 1'b0, 64'h00000001_00000002, 33);

        // start in the same cycle as flush is not accepted
        @(posedge clk); #1;
        d1[0] = 64'd9; d2[0] = 64'd4; st[0] = 1'b1; fl[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0; fl[0] = 1'b0;
        $display("dut0 start with flush: busy %b", bz[0]);
        chk("flush_start_busy", 64'(bz[0]), 64'd0);

        // flush during DONE: done stays high that cycle, idle afterwards, result kept
        @(posedge clk); #1;
        sg[0] = 1'b0; d1[0] = 64'd5; d2[0] = 64'd0; st[0] = 1'b1;
        @(posedge clk); #1;
        chk("flushdone_done_high", 64'(dn[0]), 64'd1);
        st[0] = 1'b0; fl[0] = 1'b1;
        @(posedge clk); #1 fl[0] = 1'b0;
        $display("dut0 flush in DONE: busy %b result %h", bz[0], rs[0]);
        chk("flushdone_busy", 64'(bz[0]), 64'd0);
        chk("flushdone_result", rs[0], 64'h00000005_FFFFFFFF);

        // reset mid-operation clears the held result
        @(posedge clk); #1;
        sg[0] = 1'b0; d1[0] = 64'd100; d2[0] = 64'd7; st[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; st[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        $display("dut0 reset mid-run: busy %b result %h", bz[0], rs[0]);
        chk("midrst_busy", 64'(bz[0]), 64'd0);
        chk("midrst_result", rs[0], 64'd0);

        // randomized operands, start and operand inputs toggled mid-run
        fork
            rnd_run(0, 500);
            rnd_run(1, 200);
            rnd_run(2, 1000);
        join

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
